// File: rtl/easyaxi_pkg.sv
// Shared definitions for the easyaxi master blocks.
// Holds the default AXI field widths used across the write and read
// schedulers and the W-channel scheduler FSM encoding.
package easyaxi_pkg;

  localparam int AXI_ID_W   = 4;
  localparam int AXI_LEN_W  = 8;
  localparam int AXI_DATA_W = 32;
  localparam int AXI_USER_W = 8;

  typedef enum logic {
    W_IDLE  = 1'b0,
    W_BURST = 1'b1
  } w_state_e;

endpackage

// File: rtl/easyaxi_sync_fifo.sv
// Single-clock FIFO with registered occupancy count.
// Ports:
//   clk, rst_n   clock and synchronous active-low reset (control only)
//   push, din    write request and data; ignored while full
//   pop, dout    read request; dout shows the head entry (first-word fall-through)
//   full, empty  derived from the registered count
//   count        number of stored entries (0..DEPTH)
// Full is computed from the registered count, so a push into a full FIFO is
// dropped even if a pop happens in the same cycle.
module easyaxi_sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/easyaxi_mst_w_sched.sv
// W-channel scheduler for the AXI write master.
// Records every accepted AW (slot pointer, ID, LEN) in issue order and then
// emits the W beats of each burst in that order, with WLAST on the final beat.
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   aw_fire, aw_ptr, aw_id, aw_len   accepted AW request to record
//   aw_block                         order FIFO full; gate awvalid upstream
//   w_valid/w_ready/w_data/w_strb/w_last/w_user   AXI W channel
//   w_done_vld, w_done_ptr           pulse on WLAST handshake with slot pointer
//   busy                             burst in progress or requests queued
//   ovf_err                          sticky: AW arrived while FIFO was full
module easyaxi_mst_w_sched
  import easyaxi_pkg::*;
#(
  parameter int OST_DEPTH = 16,
  parameter int PTR_W     = (OST_DEPTH > 1) ? $clog2(OST_DEPTH) : 1,
  parameter int ID_W      = AXI_ID_W,
  parameter int LEN_W     = AXI_LEN_W,
  parameter int DATA_W    = AXI_DATA_W,
  parameter int USER_W    = AXI_USER_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                aw_fire,
  input  logic [PTR_W-1:0]    aw_ptr,
  input  logic [ID_W-1:0]     aw_id,
  input  logic [LEN_W-1:0]    aw_len,
  output logic                aw_block,
  output logic                w_valid,
  input  logic                w_ready,
  output logic [DATA_W-1:0]   w_data,
  output logic [DATA_W/8-1:0] w_strb,
  output logic                w_last,
  output logic [USER_W-1:0]   w_user,
  output logic                w_done_vld,
  output logic [PTR_W-1:0]    w_done_ptr,
  output logic                busy,
  output logic                ovf_err
);

  localparam int ENT_W = PTR_W + ID_W + LEN_W;

  w_state_e         state;
  w_state_e         state_nxt;
  logic [PTR_W-1:0] act_ptr;
  logic [ID_W-1:0]  act_id;
  logic [LEN_W-1:0] act_len;
  logic [LEN_W-1:0] beat;
  logic [ENT_W-1:0] fifo_dout;
  logic             fifo_full;
  logic             fifo_empty;
  logic [PTR_W:0]   fifo_cnt;
  logic             pop;

  // Order FIFO: AW capture stage
  easyaxi_sync_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (OST_DEPTH)
  ) u_order_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (aw_fire),
    .pop   (pop),
    .din   ({aw_ptr, aw_id, aw_len}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_err <= 1'b0;
    end else if (aw_fire && fifo_full) begin
      ovf_err <= 1'b1;
    end
  end

  // Burst FSM: state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= W_IDLE;
    else        state <= state_nxt;
  end

  // Burst FSM: next state; a WLAST handshake with work queued stays in BURST
  always_comb begin
    state_nxt = state;
    case (state)
      W_IDLE:  if (!fifo_empty) state_nxt = W_BURST;
      W_BURST: if (w_ready && (beat == act_len) && fifo_empty) state_nxt = W_IDLE;
      default: state_nxt = W_IDLE;
    endcase
  end

  // Burst FSM: outputs and FIFO pop
  always_comb begin
    w_valid    = (state == W_BURST);
    w_last     = w_valid && (beat == act_len);
    w_done_vld = w_valid && w_ready && w_last && rst_n;
    pop        = !fifo_empty && ((state == W_IDLE) || (w_valid && w_ready && w_last));
  end

  // Active burst context: loaded on pop, beat advances on each non-final handshake
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      act_ptr <= '0;
      act_id  <= '0;
      act_len <= '0;
      beat    <= '0;
    end else if (pop) begin
      {act_ptr, act_id, act_len} <= fifo_dout;
      beat                       <= '0;
    end else if (w_valid && w_ready && !w_last) begin
      beat <= beat + 1'b1;
    end
  end

  assign w_data     = DATA_W'({act_id, act_ptr, beat});
  assign w_user     = USER_W'(act_id);
  assign w_strb     = '1;
  assign w_done_ptr = act_ptr;
  assign aw_block   = (fifo_cnt == (PTR_W+1)'(OST_DEPTH));
  assign busy       = (state != W_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_easyaxi_mst_w_sched.sv
// Bench for easyaxi_mst_w_sched: cycle-exact vector table for the basic
// burst shapes, hand sequences for reset/overflow corners, and a randomized
// run checked against a queue-based model of the expected W beat stream.
module tb_easyaxi_mst_w_sched;

  localparam int PW = 4;
  localparam int IW = 4;
  localparam int LW = 8;
  localparam int DW = 32;
  localparam int UW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          aw_fire = 1'b0;
  logic [PW-1:0] aw_ptr = '0;
  logic [IW-1:0] aw_id = '0;
  logic [LW-1:0] aw_len = '0;
  logic          w_ready = 1'b0;
  logic          aw_block;
  logic          w_valid;
  logic [DW-1:0] w_data;
  logic [DW/8-1:0] w_strb;
  logic          w_last;
  logic [UW-1:0] w_user;
  logic          w_done_vld;
  logic [PW-1:0] w_done_ptr;
  logic          busy;
  logic          ovf_err;

  easyaxi_mst_w_sched #(
    .OST_DEPTH (16), .PTR_W (PW), .ID_W (IW), .LEN_W (LW), .DATA_W (DW), .USER_W (UW)
  ) dut (
    .clk (clk), .rst_n (rst_n), .aw_fire (aw_fire), .aw_ptr (aw_ptr), .aw_id (aw_id),
    .aw_len (aw_len), .aw_block (aw_block), .w_valid (w_valid), .w_ready (w_ready),
    .w_data (w_data), .w_strb (w_strb), .w_last (w_last), .w_user (w_user),
    .w_done_vld (w_done_vld), .w_done_ptr (w_done_ptr), .busy (busy), .ovf_err (ovf_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  function automatic void chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, got, exp, $time);
    end
  endfunction

  // Expected W beat stream, built from the burst rules alone
  typedef struct {
    logic [31:0] data;
    logic        last;
    logic [3:0]  ptr;
    logic [3:0]  id;
  } beat_t;

  beat_t exp_q[$];
  bit    mon_en = 1'b0;

  task automatic model_push(input logic [3:0] p, input logic [3:0] id, input logic [7:0] len);
    for (int b = 0; b <= int'(len); b++) begin
      beat_t e;
      e.data = {16'h0, id, p, 8'(b)};
      e.last = (b == int'(len));
      e.ptr  = p;
      e.id   = id;
      exp_q.push_back(e);
    end
  endtask

  bit          prev_stall = 1'b0;
  logic [31:0] pd;
  logic        pl;
  logic [7:0]  pu;

  always @(negedge clk) begin : mon
    beat_t e;
    if (mon_en) begin
      if (prev_stall)
        chk("hold", {w_valid, w_data, w_last, w_user}, {1'b1, pd, pl, pu});
      if (w_valid && w_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL extra_beat: got data 0x%0h expected no beat at %0t", w_data, $time);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", w_data, e.data);
          chk("beat_last", w_last, e.last);
          chk("beat_user", w_user, 8'(e.id));
          chk("beat_done", w_done_vld, e.last);
          if (e.last) chk("beat_done_ptr", w_done_ptr, e.ptr);
        end
      end else begin
        chk("no_done", w_done_vld, 1'b0);
      end
      prev_stall = w_valid && !w_ready;
      pd = w_data;
      pl = w_last;
      pu = w_user;
    end else begin
      prev_stall = 1'b0;
    end
  end

  typedef struct {
    logic        fire;
    logic [3:0]  ptr;
    logic [3:0]  id;
    logic [7:0]  len;
    logic        rdy;
    logic        v;
    logic [31:0] data;
    logic        last;
    logic        done;
    logic [3:0]  dptr;
    logic        busy;
  } vec_t;

  function automatic vec_t mk(input bit f, input int p, input int id, input int len, input bit r,
                              input bit v, input logic [31:0] d, input bit l, input bit dn,
                              input int dp, input bit b);
    vec_t t;
    t.fire = f; t.ptr = 4'(p); t.id = 4'(id); t.len = 8'(len); t.rdy = r;
    t.v = v; t.data = d; t.last = l; t.done = dn; t.dptr = 4'(dp); t.busy = b;
    return t;
  endfunction

  vec_t tbl[30];

  task automatic do_reset();
    mon_en  = 1'b0;
    aw_fire = 1'b0;
    w_ready = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    exp_q.delete();
  endtask

  task automatic drain(input string nm);
    int t = 0;
    aw_fire = 1'b0;
    w_ready = 1'b1;
    while ((exp_q.size() != 0 || busy) && t < 4000) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    chk({nm, "_left"}, exp_q.size(), 0);
    chk({nm, "_busy"}, busy, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit");
  end

  initial begin
    bit found;

    //            fire ptr id len rdy | v  data       last done dptr busy
    tbl[0]  = mk(1, 5, 2, 3, 1,  0, 32'h0,    0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 0, 0, 1,  0, 32'h0,    0, 0, 0, 1);
    tbl[2]  = mk(0, 0, 0, 0, 1,  1, 32'h2500, 0, 0, 0, 1);
    tbl[3]  = mk(0, 0, 0, 0, 1,  1, 32'h2501, 0, 0, 0, 1);
    tbl[4]  = mk(0, 0, 0, 0, 1,  1, 32'h2502, 0, 0, 0, 1);
    tbl[5]  = mk(0, 0, 0, 0, 1,  1, 32'h2503, 1, 1, 5, 1);
    tbl[6]  = mk(0, 0, 0, 0, 1,  0, 32'h0,    0, 0, 0, 0);
    tbl[7]  = mk(1, 1, 1, 0, 1,  0, 32'h0,    0, 0, 0, 0);
    tbl[8]  = mk(1, 2, 3, 1, 1,  0, 32'h0,    0, 0, 0, 1);
    tbl[9]  = mk(0, 0, 0, 0, 1,  1, 32'h1100, 1, 1, 1, 1);
    tbl[10] = mk(0, 0, 0, 0, 1,  1, 32'h3200, 0, 0, 0, 1);
    tbl[11] = mk(0, 0, 0, 0, 1,  1, 32'h3201, 1, 1, 2, 1);
    tbl[12] = mk(0, 0, 0, 0, 1,  0, 32'h0,    0, 0, 0, 0);
    tbl[13] = mk(1, 7, 4, 3, 1,  0, 32'h0,    0, 0, 0, 0);
    tbl[14] = mk(0, 0, 0, 0, 1,  0, 32'h0,    0, 0, 0, 1);
    tbl[15] = mk(0, 0, 0, 0, 1,  1, 32'h4700, 0, 0, 0, 1);
    tbl[16] = mk(0, 0, 0, 0, 0,  1, 32'h4701, 0, 0, 0, 1);
    tbl[17] = mk(0, 0, 0, 0, 0,  1, 32'h4701, 0, 0, 0, 1);
    tbl[18] = mk(0, 0, 0, 0, 0,  1, 32'h4701, 0, 0, 0, 1);
    tbl[19] = mk(0, 0, 0, 0, 1,  1, 32'h4701, 0, 0, 0, 1);
    tbl[20] = mk(0, 0, 0, 0, 1,  1, 32'h4702, 0, 0, 0, 1);
    tbl[21] = mk(0, 0, 0, 0, 1,  1, 32'h4703, 1, 1, 7, 1);
    tbl[22] = mk(0, 0, 0, 0, 1,  0, 32'h0,    0, 0, 0, 0);
    tbl[23] = mk(1, 1, 1, 1, 1,  0, 32'h0,    0, 0, 0, 0);
    tbl[24] = mk(1, 2, 3, 0, 1,  0, 32'h0,    0, 0, 0, 1);
    tbl[25] = mk(0, 0, 0, 0, 1,  1, 32'h1100, 0, 0, 0, 1);
    tbl[26] = mk(1, 3, 5, 0, 1,  1, 32'h1101, 1, 1, 1, 1);
    tbl[27] = mk(0, 0, 0, 0, 1,  1, 32'h3200, 1, 1, 2, 1);
    tbl[28] = mk(0, 0, 0, 0, 1,  1, 32'h5300, 1, 1, 3, 1);
    tbl[29] = mk(0, 0, 0, 0, 1,  0, 32'h0,    0, 0, 0, 0);

    do_reset();
    @(negedge clk);
    chk("rst_ctl", {w_valid, w_last, w_done_vld, aw_block, busy, ovf_err}, 6'b0);
    chk("rst_data", w_data, 32'h0);
    chk("rst_strb", w_strb, 4'hF);

    // Cycle-exact table: single burst, back-to-back, backpressure, push during WLAST pop
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      aw_fire = tbl[i].fire;
      aw_ptr  = tbl[i].ptr;
      aw_id   = tbl[i].id;
      aw_len  = tbl[i].len;
      w_ready = tbl[i].rdy;
      @(negedge clk);
      chk($sformatf("tbl%0d_ctl", i), {w_valid, w_last, w_done_vld, busy},
          {tbl[i].v, tbl[i].last, tbl[i].done, tbl[i].busy});
      if (tbl[i].v)    chk($sformatf("tbl%0d_data", i), w_data, tbl[i].data);
      if (tbl[i].done) chk($sformatf("tbl%0d_dptr", i), w_done_ptr, tbl[i].dptr);
    end
    @(posedge clk);
    #1 aw_fire = 1'b0;

    // Reset during beat 2 of a len=7 burst
    @(posedge clk);
    #1;
    aw_fire = 1'b1; aw_ptr = 4'd9; aw_id = 4'd6; aw_len = 8'd7; w_ready = 1'b1;
    @(posedge clk);
    #1 aw_fire = 1'b0;
    found = 1'b0;
    for (int t = 0; t < 20; t++) begin
      if (w_valid && w_data[7:0] == 8'd2) begin
        found = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    chk("rmb_reach_beat2", found, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rmb_no_done_pre", w_done_vld, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rmb_ctl", {w_valid, w_last, w_done_vld, busy, aw_block}, 5'b0);
    chk("rmb_data", w_data, 32'h0);
    @(posedge clk);
    #1;
    aw_fire = 1'b1; aw_ptr = 4'd3; aw_id = 4'd1; aw_len = 8'd1;
    @(posedge clk);
    #1 aw_fire = 1'b0;
    found = 1'b0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (w_valid) begin
        found = 1'b1;
        break;
      end
    end
    chk("rmb_new_valid", found, 1'b1);
    chk("rmb_new_b0", {w_data, w_last, w_done_vld}, {32'h1300, 1'b0, 1'b0});
    @(negedge clk);
    chk("rmb_new_b1", {w_data, w_last, w_done_vld, w_done_ptr}, {32'h1301, 1'b1, 1'b1, 4'd3});

    // Fill and overflow with W stalled; the first burst leaves the FIFO for the
    // active registers, so the 17th push fills it and the 18th is dropped
    do_reset();
    mon_en = 1'b1;
    for (int k = 0; k < 17; k++) begin
      @(posedge clk);
      #1;
      aw_fire = 1'b1; aw_ptr = 4'(k); aw_id = 4'(k * 3); aw_len = 8'(k % 4);
      model_push(aw_ptr, aw_id, aw_len);
      @(negedge clk);
      chk($sformatf("ovf_block_pre%0d", k), aw_block, 1'b0);
    end
    @(posedge clk);
    #1;
    aw_fire = 1'b1; aw_ptr = 4'hE; aw_id = 4'hE; aw_len = 8'd2;
    @(negedge clk);
    chk("ovf_block_full", aw_block, 1'b1);
    chk("ovf_err_pre", ovf_err, 1'b0);
    @(posedge clk);
    #1 aw_fire = 1'b0;
    @(negedge clk);
    chk("ovf_err_set", ovf_err, 1'b1);
    chk("ovf_block_hold", aw_block, 1'b1);
    @(posedge clk);
    #1 drain("ovf_drain");
    chk("ovf_err_sticky", ovf_err, 1'b1);
    chk("ovf_block_clear", aw_block, 1'b0);
    do_reset();
    @(negedge clk);
    chk("ovf_err_reset", ovf_err, 1'b0);

    // Randomized traffic, AW gated by aw_block as the controller would
    mon_en = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk);
      #1;
      w_ready = ($urandom_range(9) < 7);
      if (!aw_block && $urandom_range(2) == 0) begin
        aw_fire = 1'b1;
        aw_ptr  = 4'($urandom);
        aw_id   = 4'($urandom);
        aw_len  = 8'($urandom_range(5));
        model_push(aw_ptr, aw_id, aw_len);
      end else begin
        aw_fire = 1'b0;
      end
    end
    @(posedge clk);
    #1 drain("rand_drain");
    chk("rand_ovf", ovf_err, 1'b0);
    mon_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
